spi_slave_fsm: RTL and testbench
================================

# spi_slave_fsm

SPI mode-0 slave protocol engine that sits directly downstream of the input conditioners. It consumes the conditioned chip-select, the conditioned MOSI level and the one-cycle SCK edge pulses. From these it decodes an address/command byte and then either captures a write byte into the register file or serves a read byte onto MISO. The register file itself is external: this block drives its address, write data and write strobe, and samples its combinational read data.

## Interface
- addrwidth, 7, register address width; first addrwidth bits of a frame, MSB first
- datawidth, 8, data byte width
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- cs  input  1  conditioned chip select, active low
- mosi  input  1  conditioned MOSI level
- sclk_posedge  input  1  one-clk pulse per conditioned SCK rising edge
- sclk_negedge  input  1  one-clk pulse per conditioned SCK falling edge
- rdata  input  datawidth  register-file read data, combinational from addr
- miso  output  1  serial read data, MSB of the shift register
- miso_en  output  1  MISO tri-state buffer enable, high only while serving a read
- addr  output  addrwidth  register-file address, latched from the frame
- wdata  output  datawidth  register-file write data
- we  output  1  register-file write strobe, one-clk pulse

## Operation
- Frame format: cs falls, then addrwidth address bits MSB first, then 1 R/W bit (1=read, 0=write), then datawidth data bits MSB first.
- The FSM samples mosi only in cycles where sclk_posedge=1. It shifts miso only on sclk_negedge.
- States:
  - IDLE: leave to GET_ADDR when cs=0. Clear the bit counter.
  - GET_ADDR: on each sclk_posedge, shift mosi into the shift register and increment the counter. On the (addrwidth+1)-th bit, latch addr and the R/W flag, clear the counter, then go to READ_LOAD (read) or WRITE_SHIFT (write).
  - READ_LOAD: one cycle. Load the shift register from rdata, set miso_en=1, go to READ_SHIFT.
  - READ_SHIFT: on each sclk_posedge, increment the counter. On sclk_negedge with counter>0, shift left by one, filling with 0. The negedge that follows the R/W bit does not shift, so the MSB stays presented. When the counter reaches datawidth, go to DONE.
  - WRITE_SHIFT: on each sclk_posedge, shift mosi in. After datawidth bits, copy the shift register to wdata and go to WRITE_COMMIT.
  - WRITE_COMMIT: one cycle with we=1. addr and wdata are stable. Go to DONE.
  - DONE: miso_en=0. Ignore all SCK edges. Go to IDLE when cs=1.
- cs=1 in any non-IDLE state forces IDLE on the next clk and drops miso_en.
  - An incomplete write frame never asserts we.
  - If WRITE_COMMIT is already entered, its we pulse completes.
- Extra SCK edges beyond a frame are ignored until cs rises. A new frame requires cs to go high and then low again.
- addr and wdata hold their last values between frames.

## Timing
- Reset values: miso=0, miso_en=0, addr=0, wdata=0, we=0, state=IDLE, counter=0, shift register=0.
- Reset is asynchronous. Asserting it mid-frame returns the block to IDLE immediately, with no we pulse.
- addr is valid 1 clk after the sclk_posedge pulse carrying the R/W bit.
- Read latency: miso carries rdata[MSB] and miso_en=1 exactly 2 clk after that pulse.
- Write latency: we is high for exactly 1 clk, starting 1 clk after the sclk_posedge pulse carrying the last data bit.
- Simultaneous events: cs=1 in the same cycle as an SCK pulse means cs wins; the edge is discarded.
- sclk_posedge and sclk_negedge are never both high in one cycle. If they are, the posedge is processed and the negedge is ignored.
- Precondition: the SCK half-period as seen at the pulses is at least 3 clk, so READ_LOAD completes before the first data negedge.
- Counter width: clog2(datawidth+1) bits minimum. It never wraps within a frame.

## Test plan
- Write frame: cs low, address 0x2A, R/W=0, data 0xA5 -> exactly one we pulse with addr=0x2A and wdata=0xA5. miso_en stays 0 throughout.
- Read frame: rdata model returns 0x3C for addr 0x15; send address 0x15, R/W=1 -> miso_en rises 2 clk after the 8th posedge pulse. The values of miso at each subsequent sclk_posedge are 0,0,1,1,1,1,0,0. miso_en falls after the 8th data posedge.
- Aborted write: raise cs after 4 data bits -> no we pulse, state is IDLE 1 clk later, and the next full frame decodes correctly.
- Reset mid-read: assert reset during READ_SHIFT -> miso=0, miso_en=0 and addr=0 immediately; the following write frame to 0x01 with data 0xFF pulses we correctly.
- Back-to-back frames: write 0x10←0x55, cs high for 2 clk, then read 0x10 (model returns 0x55) -> correct we pulse, then serial output 0x55. 20 extra SCK edges in DONE cause no we and no miso change.
- Simultaneous: cs rises in the same clk as the final write-data sclk_posedge -> no we pulse and the state goes to IDLE.

Source files
------------

// File: rtl/spi_slave_fsm.sv
// SPI mode-0 slave protocol engine: decodes addr/RW, then writes or reads
// one byte through an external register file.
//
// Ports:
//   clk, reset            system clock, async active-high reset
//   cs                    conditioned chip select, active low
//   mosi                  conditioned MOSI level
//   sclk_posedge/negedge  one-clk pulses per conditioned SCK edge
//   rdata                 register-file read data (combinational from addr)
//   miso, miso_en         serial read data and its tri-state enable
//   addr, wdata, we       register-file address, write data, write strobe
//
// addrwidth must not exceed datawidth: the address is collected in the
// data shift register.
module spi_slave_fsm #(
   parameter int addrwidth = 7,
   parameter int datawidth = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cs,
   input  logic                 mosi,
   input  logic                 sclk_posedge,
   input  logic                 sclk_negedge,
   input  logic [datawidth-1:0] rdata,
   output logic                 miso,
   output logic                 miso_en,
   output logic [addrwidth-1:0] addr,
   output logic [datawidth-1:0] wdata,
   output logic                 we
);

   localparam int CMAX = (addrwidth > datawidth) ?
                         addrwidth : datawidth;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] CNT_RW   = CW'(addrwidth);
   localparam logic [CW-1:0] CNT_LAST = CW'(datawidth - 1);

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      READ_LOAD,
      READ_SHIFT,
      WRITE_SHIFT,
      WRITE_COMMIT,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [datawidth-1:0]   shift_q, shift_d;
   logic [addrwidth-1:0]   addr_q, addr_d;
   logic [datawidth-1:0]   wdata_q, wdata_d;
   logic                   miso_en_q, miso_en_d;
   logic                   we_q, we_d;

   logic [datawidth-1:0]   shift_in;

   assign shift_in = {shift_q[datawidth-2:0], mosi};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!cs) state_d = GET_ADDR;
         end

         GET_ADDR: begin
            if (sclk_posedge) begin
               shift_d = shift_in;
               cnt_d   = cnt_q + CW'(1);
               // This pulse carries the R/W bit; the address
               // bits are already in the low end of shift_q.
               if (cnt_q == CNT_RW) begin
                  addr_d  = shift_q[addrwidth-1:0];
                  cnt_d   = '0;
                  state_d = mosi ? READ_LOAD : WRITE_SHIFT;
               end
            end
         end

         READ_LOAD: begin
            shift_d = rdata;
            state_d = READ_SHIFT;
         end

         READ_SHIFT: begin
            if (sclk_posedge) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) state_d = DONE;
            end else if (sclk_negedge && cnt_q != '0) begin
               // The negedge right after the R/W bit keeps the
               // MSB presented; later ones advance the byte.
               shift_d = {shift_q[datawidth-2:0], 1'b0};
            end
         end

         WRITE_SHIFT: begin
            if (sclk_posedge) begin
               shift_d = shift_in;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  wdata_d = shift_in;
                  cnt_d   = '0;
                  state_d = WRITE_COMMIT;
               end
            end
         end

         WRITE_COMMIT: state_d = DONE;

         DONE: state_d = DONE;

         default: state_d = IDLE;
      endcase

      // Chip-select release beats any SCK edge in the same cycle.
      if (state_q != IDLE && cs) begin
         state_d = IDLE;
         cnt_d   = '0;
         shift_d = shift_q;
         addr_d  = addr_q;
         wdata_d = wdata_q;
      end

      miso_en_d = (state_d == READ_SHIFT);
      we_d      = (state_d == WRITE_COMMIT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         miso_en_q <= 1'b0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         miso_en_q <= miso_en_d;
         we_q      <= we_d;
      end
   end

   assign miso    = shift_q[datawidth-1];
   assign miso_en = miso_en_q;
   assign addr    = addr_q;
   assign wdata   = wdata_q;
   assign we      = we_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm with a small register-file model.
// Inputs change 1 time unit after clk rises; outputs are read there too.
module tb_spi_slave_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       cs;
   logic       mosi;
   logic       sclk_posedge;
   logic       sclk_negedge;
   logic [7:0] rdata;
   logic       miso;
   logic       miso_en;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       we;

   int checks   = 0;
   int failures = 0;

   int we_hi     = 0;
   int en_hi     = 0;
   int miso_chg  = 0;
   logic miso_prev = 1'b0;

   logic [7:0] mem [0:127];

   always #5 clk = ~clk;

   spi_slave_fsm dut (
      .clk          (clk),
      .reset        (reset),
      .cs           (cs),
      .mosi         (mosi),
      .sclk_posedge (sclk_posedge),
      .sclk_negedge (sclk_negedge),
      .rdata        (rdata),
      .miso         (miso),
      .miso_en      (miso_en),
      .addr         (addr),
      .wdata        (wdata),
      .we           (we)
   );

   assign rdata = mem[addr];

   always @(negedge clk) begin
      if (we) begin
         we_hi = we_hi + 1;
         mem[addr] = wdata;
      end
      if (miso_en) en_hi = en_hi + 1;
      if (miso !== miso_prev) miso_chg = miso_chg + 1;
      miso_prev = miso;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One SCK period: posedge pulse, 3 clk, negedge pulse, 3 clk.
   task automatic send_bit(input logic b);
      mosi = b;
      tick();
      sclk_posedge = 1'b1;
      tick();
      sclk_posedge = 1'b0;
      tick();
      tick();
      sclk_negedge = 1'b1;
      tick();
      sclk_negedge = 1'b0;
      tick();
   endtask

   task automatic send_addr(input logic [6:0] a);
      for (int i = 0; i < 7; i++) send_bit(a[6-i]);
   endtask

   task automatic write_frame(input logic [6:0] a,
                              input logic [7:0] d);
      int we0;
      int en0;
      we0 = we_hi;
      en0 = en_hi;
      cs = 1'b0;
      tick();
      tick();
      send_addr(a);
      send_bit(1'b0);
      for (int i = 0; i < 7; i++) send_bit(d[7-i]);
      mosi = d[0];
      tick();
      sclk_posedge = 1'b1;
      tick();
      sclk_posedge = 1'b0;
      check("wr_we_on", 32'(we), 32'd1);
      check("wr_addr", 32'(addr), 32'(a));
      check("wr_wdata", 32'(wdata), 32'(d));
      tick();
      check("wr_we_off", 32'(we), 32'd0);
      tick();
      sclk_negedge = 1'b1;
      tick();
      sclk_negedge = 1'b0;
      tick();
      cs = 1'b1;
      tick();
      tick();
      check("wr_we_count", 32'(we_hi - we0), 32'd1);
      check("wr_no_en", 32'(en_hi - en0), 32'd0);
   endtask

   task automatic read_frame(input logic [6:0] a,
                             input logic [7:0] exp,
                             input int n_extra);
      logic [7:0] got;
      logic [7:0] en;
      int we0;
      int chg0;
      got = '0;
      en  = '0;
      cs = 1'b0;
      tick();
      tick();
      send_addr(a);
      mosi = 1'b1;
      tick();
      sclk_posedge = 1'b1;
      tick();
      sclk_posedge = 1'b0;
      check("rd_addr", 32'(addr), 32'(a));
      check("rd_en_lat1", 32'(miso_en), 32'd0);
      tick();
      check("rd_en_lat2", 32'(miso_en), 32'd1);
      check("rd_msb", 32'(miso), 32'(exp[7]));
      tick();
      sclk_negedge = 1'b1;
      tick();
      sclk_negedge = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         mosi = 1'b0;
         tick();
         got[7-i] = miso;
         en[7-i]  = miso_en;
         sclk_posedge = 1'b1;
         tick();
         sclk_posedge = 1'b0;
         if (i == 7) check("rd_en_fall", 32'(miso_en), 32'd0);
         tick();
         tick();
         sclk_negedge = 1'b1;
         tick();
         sclk_negedge = 1'b0;
         tick();
      end
      check("rd_byte", 32'(got), 32'(exp));
      check("rd_en_mask", 32'(en), 32'hFF);
      if (n_extra > 0) begin
         we0  = we_hi;
         chg0 = miso_chg;
         for (int k = 0; k < n_extra; k++) send_bit(k[0]);
         check("done_no_we", 32'(we_hi - we0), 32'd0);
         check("done_no_miso", 32'(miso_chg - chg0), 32'd0);
         check("done_no_en", 32'(miso_en), 32'd0);
      end
      cs = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int we0;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[7'h15] = 8'h3C;
      reset = 1'b1;
      cs = 1'b1;
      mosi = 1'b0;
      sclk_posedge = 1'b0;
      sclk_negedge = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_en", 32'(miso_en), 32'd0);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      check("rst_we", 32'(we), 32'd0);

      write_frame(7'h2A, 8'hA5);

      read_frame(7'h15, 8'h3C, 0);

      // Aborted write after 4 data bits.
      we0 = we_hi;
      cs = 1'b0;
      tick();
      tick();
      send_addr(7'h33);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      cs = 1'b1;
      tick();
      check("abort_idle", 32'(dut.state_q), 32'd0);
      tick();
      check("abort_no_we", 32'(we_hi - we0), 32'd0);
      write_frame(7'h2B, 8'h3C);

      // Reset during READ_SHIFT.
      cs = 1'b0;
      tick();
      tick();
      send_addr(7'h15);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      check("pre_rst_en", 32'(miso_en), 32'd1);
      #2;
      reset = 1'b1;
      cs = 1'b1;
      #1;
      check("arst_miso", 32'(miso), 32'd0);
      check("arst_en", 32'(miso_en), 32'd0);
      check("arst_addr", 32'(addr), 32'd0);
      check("arst_we", 32'(we), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      write_frame(7'h01, 8'hFF);

      // Back-to-back: write, 2 clk of cs high, read back.
      write_frame(7'h10, 8'h55);
      read_frame(7'h10, 8'h55, 20);

      // cs rises together with the last write-data pulse.
      we0 = we_hi;
      cs = 1'b0;
      tick();
      tick();
      send_addr(7'h22);
      send_bit(1'b0);
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      mosi = 1'b1;
      tick();
      sclk_posedge = 1'b1;
      cs = 1'b1;
      tick();
      sclk_posedge = 1'b0;
      check("simul_we", 32'(we), 32'd0);
      check("simul_idle", 32'(dut.state_q), 32'd0);
      tick();
      tick();
      check("simul_no_we", 32'(we_hi - we0), 32'd0);
      check("simul_wdata", 32'(wdata), 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
